// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI3 slave memory model used as DMA source/destination on the
// bench interconnect. Bytes live in a 2^ADDR_LENGTH register array; upper
// address bits are ignored, so accesses alias modulo the memory size.
// Ports:
//   ARESETn, ACLK                      asynchronous active-low reset, clock
//   AW* / AWVALID / AWREADY            write address channel (AWLOCK ignored)
//   W* / WVALID / WREADY               write data channel (WID ignored)
//   BID / BRESP / BVALID / BREADY      write response channel
//   AR* / ARVALID / ARREADY            read address channel (ARLOCK ignored)
//   RID / RDATA / RRESP / RLAST / RVALID / RREADY   read data channel
// Read and write channels are independent, one outstanding burst each.
module axi_mem_slave #(
    parameter int WIDTH_ID    = 4,
    parameter int WIDTH_AD    = 32,
    parameter int WIDTH_DA    = 32,
    parameter int WIDTH_DS    = WIDTH_DA / 8,
    parameter int ADDR_LENGTH = 12
) (
    input  logic                ARESETn,
    input  logic                ACLK,
    input  logic [WIDTH_ID-1:0] AWID,
    input  logic [WIDTH_AD-1:0] AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [1:0]          AWLOCK,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [WIDTH_ID-1:0] WID,
    input  logic [WIDTH_DA-1:0] WDATA,
    input  logic [WIDTH_DS-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [WIDTH_ID-1:0] BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [WIDTH_ID-1:0] ARID,
    input  logic [WIDTH_AD-1:0] ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [1:0]          ARLOCK,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [WIDTH_ID-1:0] RID,
    output logic [WIDTH_DA-1:0] RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);
    localparam int                  LANE_BITS = $clog2(WIDTH_DS);
    localparam logic [2:0]          SIZE_MAX  = 3'(LANE_BITS);
    localparam logic [WIDTH_AD-1:0] AD_ONE    = {{(WIDTH_AD-1){1'b0}}, 1'b1};
    localparam int                  MEM_BYTES = 1 << ADDR_LENGTH;
    localparam logic [1:0]          OKAY      = 2'b00;
    localparam logic [1:0]          SLVERR    = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [7:0] mem [MEM_BYTES];

    w_state_t            w_state;
    logic [WIDTH_ID-1:0] w_id;
    logic [WIDTH_AD-1:0] w_addr;
    logic [3:0]          w_len, w_cnt;
    logic [2:0]          w_size;
    logic [1:0]          w_burst;
    logic                w_err, w_lerr;

    r_state_t            r_state;
    logic [WIDTH_AD-1:0] r_addr, r_next;
    logic [3:0]          r_len, r_cnt;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic                r_err;

    logic                   w_fire;
    logic [ADDR_LENGTH-1:0] w_base, rd_base;
    logic [WIDTH_DA-1:0]    rd_word;

    logic unused_inputs;
    assign unused_inputs = ^{AWLOCK, ARLOCK, WID};

    // Address of the beat after 'a'. WRAP keeps the upper bits of the
    // (LEN+1)*2^SIZE window and lets the stepped offset roll over inside it.
    function automatic logic [WIDTH_AD-1:0] next_addr(
        input logic [WIDTH_AD-1:0] a,
        input logic [3:0]          len,
        input logic [2:0]          size,
        input logic [1:0]          burst
    );
        logic [WIDTH_AD-1:0] inc, aligned, stepped, wmask;
        inc     = AD_ONE << size;
        aligned = a & ~(inc - AD_ONE);
        stepped = aligned + inc;
        wmask   = (({{(WIDTH_AD-4){1'b0}}, len} + AD_ONE) << size) - AD_ONE;
        case (burst)
            2'b01:   next_addr = stepped;
            2'b10:   next_addr = (a & ~wmask) | (stepped & wmask);
            default: next_addr = a;
        endcase
    endfunction

    // ---------------- write path ----------------
    assign w_base = {w_addr[ADDR_LENGTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
    assign w_fire = (w_state == W_DATA) && WVALID && WREADY && !w_err;

    always_ff @(posedge ACLK) begin
        if (w_fire) begin
            for (int unsigned i = 0; i < WIDTH_DS; i++) begin
                if (WSTRB[i]) mem[w_base | ADDR_LENGTH'(i)] <= WDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= '0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_lerr  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (!AWREADY) begin
                        AWREADY <= 1'b1;
                    end else if (AWVALID) begin
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_id    <= AWID;
                        w_addr  <= AWADDR;
                        w_len   <= AWLEN;
                        w_size  <= AWSIZE;
                        w_burst <= AWBURST;
                        w_cnt   <= '0;
                        w_err   <= (AWSIZE > SIZE_MAX) || (AWBURST == 2'b11);
                        w_lerr  <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID) begin
                        if (w_cnt == w_len) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BID     <= w_id;
                            BRESP   <= (w_err || w_lerr || !WLAST) ? SLVERR : OKAY;
                            w_state <= W_RESP;
                        end else begin
                            // Early WLAST is remembered but the burst still runs to LEN.
                            if (WLAST) w_lerr <= 1'b1;
                            w_cnt  <= w_cnt + 4'd1;
                            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    // The word for the upcoming beat is looked up one cycle ahead and
    // registered, so a same-cycle write is not seen by the read.
    assign r_next  = next_addr(r_addr, r_len, r_size, r_burst);
    assign rd_base = (r_state == R_IDLE)
                   ? {ARADDR[ADDR_LENGTH-1:LANE_BITS], {LANE_BITS{1'b0}}}
                   : {r_next[ADDR_LENGTH-1:LANE_BITS], {LANE_BITS{1'b0}}};

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < WIDTH_DS; i++) begin
            rd_word[8*i +: 8] = mem[rd_base | ADDR_LENGTH'(i)];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RRESP   <= '0;
            RDATA   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (!ARREADY) begin
                        ARREADY <= 1'b1;
                    end else if (ARVALID) begin
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        RID     <= ARID;
                        r_addr  <= ARADDR;
                        r_len   <= ARLEN;
                        r_size  <= ARSIZE;
                        r_burst <= ARBURST;
                        r_cnt   <= '0;
                        RLAST   <= (ARLEN == 4'd0);
                        if ((ARSIZE > SIZE_MAX) || (ARBURST == 2'b11)) begin
                            r_err <= 1'b1;
                            RRESP <= SLVERR;
                            RDATA <= '0;
                        end else begin
                            r_err <= 1'b0;
                            RRESP <= OKAY;
                            RDATA <= rd_word;
                        end
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt  <= r_cnt + 4'd1;
                            r_addr <= r_next;
                            RDATA  <= r_err ? '0 : rd_word;
                            RLAST  <= (r_cnt + 4'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  AWID = '0, WID = '0, ARID = '0, BID, RID;
    logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
    logic [3:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0;
    logic [1:0]  AWLOCK = '0, ARLOCK = '0, AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0;
    logic        AWVALID = 1'b0, WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
    logic        ARVALID = 1'b0, RREADY = 1'b0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;

    always #5 ACLK = ~ACLK;

    axi_mem_slave #(
        .WIDTH_ID(4), .WIDTH_AD(32), .WIDTH_DA(32), .WIDTH_DS(4), .ADDR_LENGTH(12)
    ) dut (
        .ARESETn(ARESETn), .ACLK(ACLK),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mdl [4096];
    b_exp_t      bq [$];
    r_exp_t      rq [$];
    logic [31:0] wbeat [16];
    logic [3:0]  wstrb_a [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Byte address of beat k, straight from the burst rules.
    function automatic int unsigned beat_addr(input int unsigned a, input int unsigned len,
                                              input int unsigned size, input int unsigned burst,
                                              input int unsigned k);
        int unsigned inc, al, wb, lo;
        inc = 1 << size;
        al  = a - (a % inc);
        wb  = (len + 1) * inc;
        if (k == 0 || burst == 0 || burst == 3) return a;
        if (burst == 1) return al + k * inc;
        lo = a - (a % wb);
        return lo + ((al - lo + k * inc) % wb);
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0: return AWREADY;
            1: return WREADY;
            2: return BVALID;
            3: return ARREADY;
            default: return RVALID;
        endcase
    endfunction

    // Waits (bounded) until the selected ready/valid is seen high before an edge,
    // then returns #1 after that edge, where the handshake has happened.
    task automatic hs(input int w);
        int n;
        n = 0;
        @(negedge ACLK);
        while (!sig(w) && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (!sig(w)) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout_%0d actual=0 required=1", w);
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic fill_beats(input bit full_strb);
        for (int k = 0; k < 16; k++) begin
            wbeat[k]   = $urandom();
            wstrb_a[k] = full_strb ? 4'hF : 4'($urandom_range(0, 15));
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int last_beat,
                            input int bready_delay);
        bit          err;
        int unsigned ba, al;
        b_exp_t      e;
        err    = (size > 2) || (burst == 3);
        e.id   = id;
        e.resp = (err || last_beat != len) ? 2'b10 : 2'b00;
        bq.push_back(e);
        if (!err) begin
            for (int k = 0; k <= len; k++) begin
                ba = beat_addr(addr, len, size, burst, k);
                al = ba & ~32'h3;
                for (int i = 0; i < 4; i++)
                    if (wstrb_a[k][i]) mdl[(al + i) & 12'hFFF] = wbeat[k][8*i +: 8];
            end
        end
        AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
        AWVALID = 1'b1;
        hs(0);
        AWVALID = 1'b0;
        chk("aw_then_wready", {AWREADY, WREADY}, 2'b01);
        for (int k = 0; k <= len; k++) begin
            WID = id; WDATA = wbeat[k]; WSTRB = wstrb_a[k]; WLAST = (k == last_beat);
            WVALID = 1'b1;
            hs(1);
            WVALID = 1'b0;
            WLAST  = 1'b0;
            if (k != len) repeat ($urandom_range(0, 1)) begin @(posedge ACLK); #1; end
        end
        chk("wlast_then_bvalid", {WREADY, BVALID}, 2'b01);
        repeat (bready_delay) begin
            @(negedge ACLK);
            chk("b_held_awready_low", {BVALID, AWREADY}, 2'b10);
            @(posedge ACLK);
            #1;
        end
        BREADY = 1'b1;
        hs(2);
        BREADY = 1'b0;
        chk("awready_after_b", AWREADY, 1'b1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int rmode);
        bit          err;
        int unsigned ba, al;
        int          nb, n;
        r_exp_t      e;
        err = (size > 2) || (burst == 3);
        for (int k = 0; k <= len; k++) begin
            ba = beat_addr(addr, len, size, burst, k);
            al = ba & ~32'h3;
            e.id   = id;
            e.data = '0;
            if (!err) for (int i = 0; i < 4; i++) e.data[8*i +: 8] = mdl[(al + i) & 12'hFFF];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (k == len);
            rq.push_back(e);
        end
        ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
        ARVALID = 1'b1;
        hs(3);
        ARVALID = 1'b0;
        chk("ar_then_rvalid", {ARREADY, RVALID}, 2'b01);
        nb = 0;
        n  = 0;
        while (nb <= len && n < 500) begin
            case (rmode)
                0:       RREADY = 1'b1;
                1:       RREADY = n[0];
                default: RREADY = 1'($urandom_range(0, 1));
            endcase
            @(negedge ACLK);
            if (RVALID && RREADY) nb++;
            @(posedge ACLK);
            #1;
            n++;
        end
        RREADY = 1'b0;
        if (nb <= len) begin
            checks++;
            errors++;
            $display("FAIL read_beats actual=%0d required=%0d", nb, len + 1);
        end
        chk("arready_after_rlast", {ARREADY, RVALID}, 2'b10);
    endtask

    // Scoreboard monitor: checks every presented R/B word against the queue head
    // (so stalled data must stay equal to it) and pops on the handshake.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (RVALID) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected actual=%h required=none", RDATA);
                end else begin
                    chk("r_beat", {RID, RDATA, RRESP, RLAST},
                        {rq[0].id, rq[0].data, rq[0].resp, rq[0].last});
                    if (RREADY) void'(rq.pop_front());
                end
            end
            if (BVALID) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected actual=%h required=none", BRESP);
                end else begin
                    chk("b_resp", {BID, BRESP}, {bq[0].id, bq[0].resp});
                    if (BREADY) void'(bq.pop_front());
                end
            end
        end
    end

    task automatic rand_op(input bit is_write, input int unsigned base);
        int          size, burst, len;
        logic [31:0] addr;
        size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        len   = (burst == 2) ? (1 << $urandom_range(1, 4)) - 1 : int'($urandom_range(0, 7));
        addr  = ($urandom() & 32'hFFFF_F000) | (base + $urandom_range(0, 63));
        if (is_write) begin
            fill_beats(1'b0);
            do_write(4'($urandom_range(0, 15)), addr, len, size, burst, len, $urandom_range(0, 3));
        end else begin
            do_read(4'($urandom_range(0, 15)), addr, len, size, burst, $urandom_range(0, 2));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_outputs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BID, BRESP, RID, RRESP, RDATA}, '0);
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        chk("ready_low_at_release", {AWREADY, ARREADY}, 2'b00);
        @(posedge ACLK);
        #1 chk("ready_after_release", {AWREADY, ARREADY}, 2'b11);

        // Known contents for the working window (0x1000 aliases 0x000).
        for (int b = 0; b < 4; b++) begin
            fill_beats(1'b1);
            do_write(4'(b), 32'(b * 64), 15, 2, 1, 15, 0);
        end

        // INCR write/readback.
        wbeat[0] = 32'h11; wbeat[1] = 32'h22; wbeat[2] = 32'h33; wbeat[3] = 32'h44;
        for (int k = 0; k < 4; k++) wstrb_a[k] = 4'hF;
        do_write(4'h5, 32'h1000, 3, 2, 1, 3, 0);
        do_read(4'h6, 32'h1000, 3, 2, 1, 0);

        // Unaligned partial write over a zero word.
        wbeat[0] = 32'h0; wstrb_a[0] = 4'hF;
        do_write(4'h1, 32'h1000, 0, 2, 1, 0, 0);
        wbeat[0] = 32'hAABBCCDD; wstrb_a[0] = 4'hE;
        do_write(4'h2, 32'h1001, 0, 2, 1, 0, 0);
        do_read(4'h3, 32'h1000, 0, 2, 1, 0);

        // WRAP read and throttled read.
        do_read(4'h7, 32'h1008, 3, 2, 2, 0);
        do_read(4'h8, 32'h0040, 7, 2, 1, 1);

        // BREADY held low.
        fill_beats(1'b1);
        do_write(4'h9, 32'h0050, 1, 2, 1, 1, 5);

        // Error cases, followed by readback of the untouched region.
        fill_beats(1'b1);
        do_write(4'hA, 32'h0010, 1, 3, 1, 1, 0);
        do_read(4'hA, 32'h0010, 1, 2, 1, 0);
        fill_beats(1'b1);
        do_write(4'hB, 32'h0020, 3, 2, 1, 1, 0);
        do_read(4'hB, 32'h0020, 3, 2, 1, 2);
        do_read(4'hC, 32'h0030, 1, 3, 1, 0);
        do_read(4'hD, 32'h0030, 1, 2, 3, 0);

        // Concurrent read and write on different addresses.
        fill_beats(1'b1);
        fork
            do_write(4'h4, 32'h0060, 7, 2, 1, 7, 1);
            do_read(4'h5, 32'h00A0, 7, 2, 1, 2);
        join

        // Reset pulsed while beat 2 of a 4-beat write is presented.
        fill_beats(1'b1);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) mdl[32'h0C0 + 4*k + i] = wbeat[k][8*i +: 8];
        AWID = 4'h9; AWADDR = 32'h00C0; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
        AWVALID = 1'b1;
        hs(0);
        AWVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            WDATA = wbeat[k]; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
            hs(1);
        end
        WDATA = wbeat[2];
        #1 ARESETn = 1'b0;
        #1 chk("outputs_in_reset", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BID, BRESP, RID, RRESP, RDATA}, '0);
        WVALID = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(posedge ACLK);
        #1 chk("ready_after_midburst_reset", {AWREADY, ARREADY, WREADY}, 3'b110);
        do_read(4'hE, 32'h00C0, 3, 2, 1, 0);

        // Randomized traffic; concurrent pairs use disjoint halves of the window.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: rand_op(1'b1, $urandom_range(0, 1) * 128);
                1: rand_op(1'b0, $urandom_range(0, 1) * 128);
                default: fork
                    rand_op(1'b1, 0);
                    rand_op(1'b0, 128);
                join
            endcase
        end

        repeat (3) @(posedge ACLK);
        #1 chk("queues_drained", 64'(rq.size() + bq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
